// File: rtl/ccip_c0_rd_arbiter_if.sv
// Bundle of requester, CCI-P c0 TX/RX and status signals for the c0 read arbiter.
// master: the arbiter side; slave: requesters plus the CCI-P shell.
interface ccip_c0_rd_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 12
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][41:0]      req_addr;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          c0_almfull;
    logic                          tx_c0_valid;
    logic [41:0]                   tx_c0_addr;
    logic [15:0]                   tx_c0_mdata;

    logic                          rx_c0_valid;
    logic [15:0]                   rx_c0_mdata;
    logic [511:0]                  rx_c0_data;

    logic [NUM_REQ-1:0]            rsp_valid;
    logic [TAG_W-1:0]              rsp_tag;
    logic [511:0]                  rsp_data;

    logic [7:0]                    outst_cnt;
    logic                          err_sticky;

    modport master (
        input  req_valid, req_addr, req_tag, c0_almfull,
        input  rx_c0_valid, rx_c0_mdata, rx_c0_data,
        output req_ready, tx_c0_valid, tx_c0_addr, tx_c0_mdata,
        output rsp_valid, rsp_tag, rsp_data, outst_cnt, err_sticky
    );

    modport slave (
        output req_valid, req_addr, req_tag, c0_almfull,
        output rx_c0_valid, rx_c0_mdata, rx_c0_data,
        input  req_ready, tx_c0_valid, tx_c0_addr, tx_c0_mdata,
        input  rsp_valid, rsp_tag, rsp_data, outst_cnt, err_sticky
    );
endinterface

// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read channel among NUM_REQ requesters,
// with an outstanding-read cap, requester tagging in mdata and response steering.
module ccip_c0_rd_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_OUTST = 64,
    parameter int unsigned TAG_W     = 12
) (
    input logic                    pClk,
    input logic                    SoftReset,
    ccip_c0_rd_arbiter_if.master   bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W:0]     cand_ext;
    logic [PTR_W:0]     next_ext;
    logic [PTR_W-1:0]   cand;
    logic               found;
    logic               issue;
    logic [NUM_REQ-1:0] grant;
    logic [15:0]        tx_mdata_d;

    logic               tx_valid_q;
    logic [41:0]        tx_addr_q;
    logic [15:0]        tx_mdata_q;

    logic [2:0]         rsp_idx;
    logic               rsp_bad;
    logic               rsp_ok;
    logic [NUM_REQ-1:0] rsp_onehot;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [511:0]       rsp_data_q;

    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic               err_q;

    // Scan from ptr_q upward, wrapping; the first valid requester wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand_ext  = '0;
        cand      = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand_ext = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand_ext >= (PTR_W+1)'(NUM_REQ)) begin
                cand_ext = cand_ext - (PTR_W+1)'(NUM_REQ);
            end
            cand = cand_ext[PTR_W-1:0];
            if (!found && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Reset gates the grant so req_ready drops the moment SoftReset rises.
    assign issue = found && !bus.c0_almfull && (cnt_q < 8'(MAX_OUTST)) && !SoftReset;

    always_comb begin
        grant = '0;
        if (issue) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        next_ext = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (next_ext >= (PTR_W+1)'(NUM_REQ)) begin
            next_ext = '0;
        end
        ptr_next = next_ext[PTR_W-1:0];
    end

    always_comb begin
        tx_mdata_d              = '0;
        tx_mdata_d[15:13]       = 3'(grant_idx);
        tx_mdata_d[TAG_W-1:0]   = bus.req_tag[grant_idx];
    end

    // Responses are rejected when nothing is in flight or the index names no requester.
    assign rsp_idx = bus.rx_c0_mdata[15:13];
    assign rsp_bad = (cnt_q == 8'd0) || ({1'b0, rsp_idx} >= 4'(NUM_REQ));
    assign rsp_ok  = bus.rx_c0_valid && !rsp_bad;

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            rsp_onehot[i] = rsp_ok && (rsp_idx == 3'(i));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({issue, rsp_ok})
            2'b10:   cnt_d = cnt_q + 8'd1;
            2'b01:   cnt_d = cnt_q - 8'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            ptr_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_mdata_q  <= '0;
            rsp_valid_q <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            tx_valid_q <= issue;
            if (issue) begin
                ptr_q      <= ptr_next;
                tx_addr_q  <= bus.req_addr[grant_idx];
                tx_mdata_q <= tx_mdata_d;
            end
            rsp_valid_q <= rsp_onehot;
            if (bus.rx_c0_valid) begin
                rsp_tag_q  <= bus.rx_c0_mdata[TAG_W-1:0];
                rsp_data_q <= bus.rx_c0_data;
            end
            cnt_q <= cnt_d;
            if (bus.rx_c0_valid && rsp_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    generate
        if (TAG_W < 13) begin : g_pad_unused
            logic pad_unused;
            assign pad_unused = ^bus.rx_c0_mdata[12:TAG_W];
        end
    endgenerate

    assign bus.req_ready   = grant;
    assign bus.tx_c0_valid = tx_valid_q;
    assign bus.tx_c0_addr  = tx_addr_q;
    assign bus.tx_c0_mdata = tx_mdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.outst_cnt   = cnt_q;
    assign bus.err_sticky  = err_q;
endmodule
